// File: rtl/uart_pkg.sv
// UART transmitter shared definitions.
// Default timing constants, frame geometry and FSM state type.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ     = 100_000_000;
  localparam int BAUD_RATE    = 57600;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_BITS   = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Baud tick generator: one-clock tick in the last clock of each bit.
// Counter is held at zero while disabled so every frame starts aligned.
module baud_gen #(
  parameter int CLKS = 1736
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/transmitter.sv
// UART 8N1 transmitter with integrated baud generator.
// Start bit, WIDTH data bits LSB first, stop bit; line idles high.
module transmitter #(
  parameter int WIDTH     = uart_pkg::DATA_W,
  parameter int CLK_FREQ  = uart_pkg::CLK_FREQ,
  parameter int BAUD_RATE = uart_pkg::BAUD_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             tx,
  output logic             baud,
  output logic [3:0]       bit_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [3:0] LAST_DATA = 4'(WIDTH);
  localparam logic [3:0] STOP_IDX  = 4'(WIDTH + 1);

  uart_pkg::tx_state_e state;
  logic [WIDTH-1:0]    shreg;
  logic                tick;

  baud_gen #(
    .CLKS(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .enable(state != uart_pkg::IDLE),
    .tick  (tick)
  );

  assign baud = tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= uart_pkg::IDLE;
      shreg     <= '0;
      tx        <= 1'b1;
      bit_count <= '0;
    end else begin
      unique case (state)
        uart_pkg::IDLE: begin
          tx        <= 1'b1;
          bit_count <= '0;
          if (start) begin
            shreg <= data;
            state <= uart_pkg::START;
            tx    <= 1'b0;
          end
        end
        uart_pkg::START: begin
          if (tick) begin
            state     <= uart_pkg::DATA;
            bit_count <= 4'd1;
            tx        <= shreg[0];
          end
        end
        uart_pkg::DATA: begin
          if (tick) begin
            if (bit_count == LAST_DATA) begin
              state     <= uart_pkg::STOP;
              bit_count <= STOP_IDX;
              tx        <= 1'b1;
            end else begin
              shreg     <= shreg >> 1;
              bit_count <= bit_count + 4'd1;
              tx        <= shreg[1];
            end
          end
        end
        uart_pkg::STOP: begin
          if (tick) begin
            bit_count <= '0;
            // back-to-back frames reuse the stop-bit boundary, no idle gap
            if (start) begin
              shreg <= data;
              state <= uart_pkg::START;
              tx    <= 1'b0;
            end else begin
              state <= uart_pkg::IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: state <= uart_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for the UART transmitter.
// Expected bits are queued per frame and checked at each baud tick.
module tb_transmitter;

  localparam int CPB = 17;
  localparam int NB  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       baud;
  logic [3:0] bit_count;

  typedef struct {
    logic       tx;
    logic [3:0] bc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs = 0;
  int last_stop = 0;
  int b2b_starts = 0;
  logic prev_tx = 1'b1;
  logic [3:0] prev_bc = 4'd0;

  transmitter #(
    .WIDTH    (8),
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(5_760_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .tx       (tx),
    .baud     (baud),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_frame(input logic [7:0] d);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.bc = 4'(i);
      if (i == 0) e.tx = 1'b0;
      else if (i == NB - 1) e.tx = 1'b1;
      else e.tx = d[i-1];
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: pops one expected bit per baud tick
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_tx = 1'b1;
        prev_bc = 4'd0;
      end else begin
        if (prev_tx && !tx && bit_count == 4'd0) begin
          if (prev_bc == 4'(NB - 1)) begin
            b2b_starts++;
            chk("b2b_gap", cyc, last_stop + 1);
          end
          fs = cyc;
        end
        if (baud) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_baud", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tx_bit", int'(tx), int'(e.tx));
            chk("bit_count", int'(bit_count), int'(e.bc));
            chk("bit_timing", cyc - fs + 1, (int'(e.bc) + 1) * CPB);
            if (e.bc == 4'(NB - 1)) last_stop = cyc;
          end
        end
        prev_tx = tx;
        prev_bc = bit_count;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * NB * CPB) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", int'(tx), 1);
      chk("idle_bc", int'(bit_count), 0);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    // reset held with start asserted
    reset = 1'b0;
    start = 1'b1;
    data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_baud", int'(baud), 0);
      chk("rst_bc", int'(bit_count), 0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle(3);

    // 0x99, start held for several bits, data disturbed mid-frame
    data  = 8'h99;
    start = 1'b1;
    push_frame(8'h99);
    wait_cycles(2 * CPB);
    data = 8'h00;
    wait_cycles(4 * CPB);
    start = 1'b0;
    drain("drain_99");
    check_idle(2 * CPB);

    // 0x70 after a fresh reset, single-clock request
    reset = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);
    data  = 8'h70;
    start = 1'b1;
    push_frame(8'h70);
    @(negedge clk);
    start = 1'b0;
    data  = 8'hFF;
    drain("drain_70");
    check_idle(2 * CPB);

    // back-to-back 0x55 then 0xA3
    data  = 8'h55;
    start = 1'b1;
    push_frame(8'h55);
    push_frame(8'hA3);
    wait_cycles(3 * CPB);
    data = 8'hA3;
    wait_cycles(8 * CPB);
    start = 1'b0;
    data  = 8'h00;
    drain("drain_b2b");
    chk("b2b_count", b2b_starts, 1);
    check_idle(2 * CPB);

    // mid-frame reset during data bit 4
    data  = 8'h00;
    start = 1'b1;
    push_frame(8'h00);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bit_count != 4'd4 && n < 2 * NB * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit4", int'(bit_count), 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_tx", int'(tx), 1);
    chk("async_bc", int'(bit_count), 0);
    chk("async_baud", int'(baud), 0);
    exp_q.delete();
    wait_cycles(3);
    reset = 1'b1;
    check_idle(3 * CPB);
    chk("leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
